// File: rtl/inv_spi_master.sv
// inv_spi_master: 16-bit CPOL=0 SPI master polling a remote responder in a
// fixed 4-slot round robin; each reply word is kept per slot.
// Ports:
//   clk_100, RSTn        system clock, async active-low reset
//   enable               1 = keep polling, 0 = stop after current frame
//   tx_payload0..3       14-bit payloads for slots 0..3
//   SPICLK/SPISIMO/SPISTE   SCK (idle low), MOSI (MSB first), frame enable (low)
//   SPISOMI              MISO, asynchronous to clk_100
//   rx_word0..3          last word received in slot 0..3
//   rx_valid, rx_slot    one-cycle store pulse and its slot index
//   busy                 high from STE fall to end of gap
module inv_spi_master #(
   parameter int CLK_DIV    = 25,
   parameter int GAP_CYCLES = 100
) (
   input  logic        clk_100,
   input  logic        RSTn,
   input  logic        enable,
   input  logic [13:0] tx_payload0,
   input  logic [13:0] tx_payload1,
   input  logic [13:0] tx_payload2,
   input  logic [13:0] tx_payload3,
   output logic        SPICLK,
   output logic        SPISIMO,
   input  logic        SPISOMI,
   output logic        SPISTE,
   output logic [15:0] rx_word0,
   output logic [15:0] rx_word1,
   output logic [15:0] rx_word2,
   output logic [15:0] rx_word3,
   output logic        rx_valid,
   output logic [1:0]  rx_slot,
   output logic        busy
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE, S_GAP
   } state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [4:0]  r_bit;
   logic [1:0]  r_slot;
   logic [15:0] r_tx;
   logic [15:0] r_rx;
   logic        r_somi_m;
   logic        r_somi_s;

   logic [13:0] w_payload;
   logic [15:0] w_frame;
   logic        w_div_end;
   logic        w_gap_end;

   always_comb begin
      w_payload = tx_payload0;
      case (r_slot)
         2'd0: w_payload = tx_payload0;
         2'd1: w_payload = tx_payload1;
         2'd2: w_payload = tx_payload2;
         2'd3: w_payload = tx_payload3;
         default: w_payload = tx_payload0;
      endcase
   end

   assign w_frame   = {r_slot, w_payload};
   assign w_div_end = (r_cnt == DIV_LAST);
   assign w_gap_end = (r_cnt == GAP_LAST);

   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         r_somi_m <= 1'b0;
         r_somi_s <= 1'b0;
      end else begin
         r_somi_m <= SPISOMI;
         r_somi_s <= r_somi_m;
      end
   end

   always_ff @(posedge clk_100 or negedge RSTn) begin
      if (!RSTn) begin
         r_state  <= S_IDLE;
         r_cnt    <= 16'd0;
         r_bit    <= 5'd0;
         r_slot   <= 2'd0;
         r_tx     <= 16'd0;
         r_rx     <= 16'd0;
         SPICLK   <= 1'b0;
         SPISIMO  <= 1'b0;
         SPISTE   <= 1'b1;
         rx_word0 <= 16'd0;
         rx_word1 <= 16'd0;
         rx_word2 <= 16'd0;
         rx_word3 <= 16'd0;
         rx_valid <= 1'b0;
         rx_slot  <= 2'd0;
         busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= 16'd0;
               if (enable) begin
                  r_state <= S_SETUP;
                  r_tx    <= w_frame;
                  SPISIMO <= w_frame[15];
                  SPISTE  <= 1'b0;
                  busy    <= 1'b1;
                  r_bit   <= 5'd0;
               end
            end
            S_SETUP: begin
               if (w_div_end) begin
                  r_state <= S_HIGH;
                  r_cnt   <= 16'd0;
                  SPICLK  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_HIGH: begin
               if (w_div_end) begin
                  r_state <= S_LOW;
                  r_cnt   <= 16'd0;
                  SPICLK  <= 1'b0;
                  r_rx    <= {r_rx[14:0], r_somi_s};
                  r_bit   <= r_bit + 5'd1;
                  // after the 16th bit MOSI just holds through the final low
                  if (r_bit != 5'd15) begin
                     r_tx    <= {r_tx[14:0], 1'b0};
                     SPISIMO <= r_tx[14];
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_LOW: begin
               if (w_div_end) begin
                  r_cnt <= 16'd0;
                  if (r_bit == 5'd16) begin
                     r_state  <= S_DONE;
                     SPISTE   <= 1'b1;
                     SPISIMO  <= 1'b0;
                     rx_valid <= 1'b1;
                     rx_slot  <= r_slot;
                     r_slot   <= r_slot + 2'd1;
                     case (r_slot)
                        2'd0: rx_word0 <= r_rx;
                        2'd1: rx_word1 <= r_rx;
                        2'd2: rx_word2 <= r_rx;
                        2'd3: rx_word3 <= r_rx;
                        default: rx_word0 <= r_rx;
                     endcase
                  end else begin
                     r_state <= S_HIGH;
                     SPICLK  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DONE: begin
               rx_valid <= 1'b0;
               r_state  <= S_GAP;
               r_cnt    <= 16'd0;
            end
            S_GAP: begin
               if (w_gap_end) begin
                  r_cnt <= 16'd0;
                  if (enable) begin
                     r_state <= S_SETUP;
                     r_tx    <= w_frame;
                     SPISIMO <= w_frame[15];
                     SPISTE  <= 1'b0;
                     r_bit   <= 5'd0;
                  end else begin
                     r_state <= S_IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_spi_master.sv
// tb_inv_spi_master: directed bench for inv_spi_master with a shift-register
// responder model; one instance at CLK_DIV=4/GAP=8, one at CLK_DIV=2/GAP=3.
module tb_inv_spi_master;

   logic        clk_100 = 1'b0;
   logic        RSTn = 1'b1;
   logic        enable = 1'b0;
   logic [13:0] tx_payload0 = '0;
   logic [13:0] tx_payload1 = '0;
   logic [13:0] tx_payload2 = '0;
   logic [13:0] tx_payload3 = '0;
   logic        SPICLK, SPISIMO, SPISTE, rx_valid, busy;
   logic        SPISOMI = 1'b0;
   logic [15:0] rx_word0, rx_word1, rx_word2, rx_word3;
   logic [1:0]  rx_slot;

   logic        b_enable = 1'b0;
   logic        b_sck, b_simo, b_ste, b_rx_valid, b_busy;
   logic        b_somi = 1'b0;
   logic [15:0] b_rx_word0, b_rx_word1, b_rx_word2, b_rx_word3;
   logic [1:0]  b_rx_slot;

   int total = 0;
   int bad = 0;

   always #5 clk_100 = ~clk_100;

   inv_spi_master #(.CLK_DIV(4), .GAP_CYCLES(8)) u_a (
      .clk_100(clk_100), .RSTn(RSTn), .enable(enable),
      .tx_payload0(tx_payload0), .tx_payload1(tx_payload1),
      .tx_payload2(tx_payload2), .tx_payload3(tx_payload3),
      .SPICLK(SPICLK), .SPISIMO(SPISIMO), .SPISOMI(SPISOMI),
      .SPISTE(SPISTE),
      .rx_word0(rx_word0), .rx_word1(rx_word1),
      .rx_word2(rx_word2), .rx_word3(rx_word3),
      .rx_valid(rx_valid), .rx_slot(rx_slot), .busy(busy)
   );

   inv_spi_master #(.CLK_DIV(2), .GAP_CYCLES(3)) u_b (
      .clk_100(clk_100), .RSTn(RSTn), .enable(b_enable),
      .tx_payload0(14'h0155), .tx_payload1(14'h0000),
      .tx_payload2(14'h0000), .tx_payload3(14'h0000),
      .SPICLK(b_sck), .SPISIMO(b_simo), .SPISOMI(b_somi),
      .SPISTE(b_ste),
      .rx_word0(b_rx_word0), .rx_word1(b_rx_word1),
      .rx_word2(b_rx_word2), .rx_word3(b_rx_word3),
      .rx_valid(b_rx_valid), .rx_slot(b_rx_slot), .busy(b_busy)
   );

   // responder A: reply = s_base + (frames since reset)
   logic [15:0] s_base = 16'h0000;
   logic [15:0] s_sh = 16'h0000;
   int          n_fall = 0;
   always @(negedge RSTn) n_fall = 0;
   always @(negedge SPISTE) if (RSTn) begin
      s_sh = s_base + 16'(n_fall);
      n_fall++;
      SPISOMI = s_sh[15];
   end
   always @(negedge SPICLK) if (!SPISTE) begin
      s_sh = {s_sh[14:0], 1'b0};
      SPISOMI = s_sh[15];
   end

   // responder B: fixed reply
   logic [15:0] b_sh = 16'h0000;
   always @(negedge b_ste) if (RSTn) begin
      b_sh = 16'hA5C3;
      b_somi = b_sh[15];
   end
   always @(negedge b_sck) if (!b_ste) begin
      b_sh = {b_sh[14:0], 1'b0};
      b_somi = b_sh[15];
   end

   // frame monitor for instance A
   int          cyc = 0;
   logic        p_ste = 1'b1;
   logic        p_sck = 1'b0;
   int          cur_len = 0, cur_rises = 0, cur_delay = 0, cur_fall = 0;
   logic [15:0] cur_word = 16'h0;
   int          frames = 0;
   logic [15:0] fr_word[$];
   int          fr_len[$], fr_rises[$], fr_delay[$], fr_fall[$];
   int          rxv_cnt = 0;
   logic [1:0]  rxv_slot = 2'd0;

   always @(negedge clk_100) begin
      cyc++;
      if (!RSTn) begin
         p_ste = 1'b1;
         p_sck = 1'b0;
         cur_rises = 0;
      end else begin
         if (p_ste && !SPISTE) begin
            cur_len = 0;
            cur_rises = 0;
            cur_word = 16'h0;
            cur_fall = cyc;
            cur_delay = -1;
         end
         if (!SPISTE) begin
            if (SPICLK && !p_sck) begin
               if (cur_rises == 0) cur_delay = cur_len;
               cur_rises++;
               cur_word = {cur_word[14:0], SPISIMO};
            end
            cur_len++;
         end
         if (!p_ste && SPISTE) begin
            fr_word.push_back(cur_word);
            fr_len.push_back(cur_len);
            fr_rises.push_back(cur_rises);
            fr_delay.push_back(cur_delay);
            fr_fall.push_back(cur_fall);
            cur_rises = 0;
            frames++;
         end
         if (rx_valid) begin
            rxv_cnt++;
            rxv_slot = rx_slot;
         end
         p_ste = SPISTE;
         p_sck = SPICLK;
      end
   end

   function automatic logic [15:0] rxw(input int s);
      case (s)
         0: return rx_word0;
         1: return rx_word1;
         2: return rx_word2;
         default: return rx_word3;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_100);
      #1;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int c = 0;
      while (frames < n && c < budget) begin
         tick(1);
         c++;
      end
      if (frames < n) begin
         total++; bad++;
         $display("FAIL wait_frames got=%0d want=%0d", frames, n);
      end
   endtask

   task automatic wait_bit(input int n, input int b, input int budget);
      int c = 0;
      while (!(frames == n && !SPISTE && cur_rises >= b) && c < budget) begin
         tick(1);
         c++;
      end
      if (c >= budget) begin
         total++; bad++;
         $display("FAIL wait_bit frame=%0d bit=%0d got_frames=%0d", n, b, frames);
      end
   endtask

   int fb = 0;

   task automatic test_reset();
      #2 RSTn = 1'b0;
      tick(3);
      total++; if (SPICLK !== 1'b0) begin bad++; $display("FAIL rst_sck got=%b want=0", SPICLK); end
      total++; if (SPISIMO !== 1'b0) begin bad++; $display("FAIL rst_simo got=%b want=0", SPISIMO); end
      total++; if (SPISTE !== 1'b1) begin bad++; $display("FAIL rst_ste got=%b want=1", SPISTE); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", rx_valid); end
      total++; if (rx_slot !== 2'd0) begin bad++; $display("FAIL rst_slot got=%0d want=0", rx_slot); end
      total++;
      if ({rx_word0, rx_word1, rx_word2, rx_word3} !== 64'h0) begin
         bad++; $display("FAIL rst_words got=%h want=0", {rx_word0, rx_word1, rx_word2, rx_word3});
      end
      RSTn = 1'b1;
      tick(2);
   endtask

   task automatic test_basic();
      tx_payload0 = 14'h0ABC;
      s_base = 16'h1234;
      enable = 1'b1;
      tick(1);
      enable = 1'b0;
      wait_frames(1, 400);
      total++; if (fr_word[0] !== 16'h0ABC) begin bad++; $display("FAIL basic_simo got=%h want=0abc", fr_word[0]); end
      total++; if (fr_len[0] != 132) begin bad++; $display("FAIL basic_ste_len got=%0d want=132", fr_len[0]); end
      total++; if (fr_rises[0] != 16) begin bad++; $display("FAIL basic_rises got=%0d want=16", fr_rises[0]); end
      total++; if (fr_delay[0] != 4) begin bad++; $display("FAIL basic_first_rise got=%0d want=4", fr_delay[0]); end
      total++; if (rx_word0 !== 16'h1234) begin bad++; $display("FAIL basic_rx0 got=%h want=1234", rx_word0); end
      total++; if (rxv_cnt != 1) begin bad++; $display("FAIL basic_valid_cnt got=%0d want=1", rxv_cnt); end
      total++; if (rxv_slot !== 2'd0) begin bad++; $display("FAIL basic_rx_slot got=%0d want=0", rxv_slot); end
      tick(15);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
      total++; if (frames != 1) begin bad++; $display("FAIL basic_one_frame got=%0d want=1", frames); end
   endtask

   task automatic test_round_robin();
      logic [15:0] e [5];
      int v0;
      e[0] = 16'h0001; e[1] = 16'h4002; e[2] = 16'h8003;
      e[3] = 16'hC004; e[4] = 16'h0001;
      RSTn = 1'b0;
      tick(2);
      RSTn = 1'b1;
      tx_payload0 = 14'h0001; tx_payload1 = 14'h0002;
      tx_payload2 = 14'h0003; tx_payload3 = 14'h0004;
      s_base = 16'hD000;
      fb = frames;
      v0 = rxv_cnt;
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_frames(fb + k + 1, 400);
         total++;
         if (fr_word[fb+k] !== e[k]) begin
            bad++; $display("FAIL rr_word%0d got=%h want=%h", k, fr_word[fb+k], e[k]);
         end
         total++;
         if (rxw(k % 4) !== 16'hD000 + 16'(k)) begin
            bad++; $display("FAIL rr_rx%0d got=%h want=%h", k, rxw(k % 4), 16'hD000 + 16'(k));
         end
         if (k == 0) begin
            total++; if (rx_word1 !== 16'h0) begin bad++; $display("FAIL rr_rx1_early got=%h want=0", rx_word1); end
         end
         if (k == 3) begin
            total++; if (rx_word0 !== 16'hD000) begin bad++; $display("FAIL rr_rx0_hold got=%h want=d000", rx_word0); end
         end
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (fr_fall[fb+k+1] - fr_fall[fb+k] != 141) begin
            bad++; $display("FAIL rr_period%0d got=%0d want=141", k, fr_fall[fb+k+1] - fr_fall[fb+k]);
         end
      end
      total++; if (rxv_cnt - v0 != 5) begin bad++; $display("FAIL rr_valid_cnt got=%0d want=5", rxv_cnt - v0); end
   endtask

   task automatic test_stop();
      wait_bit(fb + 6, 5, 600);
      enable = 1'b0;
      wait_frames(fb + 7, 400);
      total++; if (fr_word[fb+6] !== 16'h8003) begin bad++; $display("FAIL stop_word got=%h want=8003", fr_word[fb+6]); end
      total++; if (fr_rises[fb+6] != 16) begin bad++; $display("FAIL stop_rises got=%0d want=16", fr_rises[fb+6]); end
      total++; if (rx_word2 !== 16'hD006) begin bad++; $display("FAIL stop_rx2 got=%h want=d006", rx_word2); end
      tick(30);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", busy); end
      total++; if (frames != fb + 7) begin bad++; $display("FAIL stop_no_frame got=%0d want=%0d", frames, fb + 7); end
      enable = 1'b1;
      wait_frames(fb + 8, 400);
      total++; if (fr_word[fb+7] !== 16'hC004) begin bad++; $display("FAIL stop_resume got=%h want=c004", fr_word[fb+7]); end
   endtask

   task automatic test_payload_change();
      tx_payload1 = 14'h1111;
      wait_bit(fb + 9, 8, 600);
      tx_payload1 = 14'h2222;
      wait_frames(fb + 10, 400);
      total++; if (fr_word[fb+9] !== 16'h5111) begin bad++; $display("FAIL pl_cur got=%h want=5111", fr_word[fb+9]); end
      wait_frames(fb + 14, 800);
      total++; if (fr_word[fb+13] !== 16'h6222) begin bad++; $display("FAIL pl_next got=%h want=6222", fr_word[fb+13]); end
   endtask

   task automatic test_reset_mid();
      int f0, v0;
      wait_bit(fb + 14, 10, 600);
      f0 = frames;
      v0 = rxv_cnt;
      RSTn = 1'b0;
      #1;
      total++; if (SPISTE !== 1'b1) begin bad++; $display("FAIL rm_ste got=%b want=1", SPISTE); end
      total++; if (SPICLK !== 1'b0) begin bad++; $display("FAIL rm_sck got=%b want=0", SPICLK); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
      total++;
      if ({rx_word0, rx_word1, rx_word2, rx_word3} !== 64'h0) begin
         bad++; $display("FAIL rm_words got=%h want=0", {rx_word0, rx_word1, rx_word2, rx_word3});
      end
      s_base = 16'hA5C3;
      tick(3);
      total++; if (rxv_cnt != v0) begin bad++; $display("FAIL rm_no_valid got=%0d want=%0d", rxv_cnt, v0); end
      RSTn = 1'b1;
      wait_frames(f0 + 1, 400);
      total++; if (fr_word[f0] !== 16'h0001) begin bad++; $display("FAIL rm_first_tag got=%h want=0001", fr_word[f0]); end
      total++; if (rx_word0 !== 16'hA5C3) begin bad++; $display("FAIL somi_div4 got=%h want=a5c3", rx_word0); end
   endtask

   task automatic test_somi_div2();
      int c = 0;
      int low = 0;
      logic got = 1'b0;
      b_enable = 1'b1;
      tick(1);
      b_enable = 1'b0;
      while (!got && c < 300) begin
         if (!b_ste) low++;
         if (b_rx_valid) got = 1'b1;
         else tick(1);
         c++;
      end
      total++; if (got !== 1'b1) begin bad++; $display("FAIL div2_valid got=%b want=1", got); end
      total++; if (b_rx_word0 !== 16'hA5C3) begin bad++; $display("FAIL div2_rx0 got=%h want=a5c3", b_rx_word0); end
      total++; if (b_rx_slot !== 2'd0) begin bad++; $display("FAIL div2_slot got=%0d want=0", b_rx_slot); end
      total++; if (low != 66) begin bad++; $display("FAIL div2_ste_len got=%0d want=66", low); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_stop();
      test_payload_change();
      test_reset_mid();
      test_somi_div2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
